// File: rtl/scumv_asc_pkg.sv
// Shared ASC definitions: status codes, framer state enum
// and the frame-length helper used by framer and shifter.
package scumv_asc_pkg;

  localparam logic [7:0] ASC_ACK = 8'h06;
  localparam logic [7:0] ASC_NAK = 8'h15;

  typedef enum logic [1:0] {
    ST_COLLECT,
    ST_ISSUE,
    ST_RESP
  } asc_state_e;

  function automatic int cmd_bytes(
    input int addr_bits,
    input int payload_bits
  );
    return (addr_bits + payload_bits + 7) / 8;
  endfunction

endpackage

// File: rtl/scan_cmd_assembler_if.sv
// Byte in, command out and status out streams of the ASC framer.
// slave: framer side; master: UART handler / shifter side.
interface scan_cmd_assembler_if #(
  parameter int ADDR_BITS    = 12,
  parameter int PAYLOAD_BITS = 160
);
  logic                    data_valid;
  logic                    data_ready;
  logic [7:0]              data_in;
  logic                    cmd_valid;
  logic                    cmd_ready;
  logic [ADDR_BITS-1:0]    cmd_addr;
  logic [PAYLOAD_BITS-1:0] cmd_payload;
  logic                    response_valid;
  logic                    response_ready;
  logic [7:0]              response_data;
  logic                    busy;

  modport slave (
    input  data_valid, data_in,
    input  cmd_ready, response_ready,
    output data_ready,
    output cmd_valid, cmd_addr, cmd_payload,
    output response_valid, response_data,
    output busy
  );

  modport master (
    output data_valid, data_in,
    output cmd_ready, response_ready,
    input  data_ready,
    input  cmd_valid, cmd_addr, cmd_payload,
    input  response_valid, response_data,
    input  busy
  );
endinterface

// File: rtl/scan_cmd_assembler.sv
// Frames CMD_BYTES little-endian bytes into an addr+payload command,
// answers ACK per command or NAK after an inter-byte timeout.
// Ports: clk, reset (async active-low), bus (slave modport).
module scan_cmd_assembler
  import scumv_asc_pkg::*;
#(
  parameter int ADDR_BITS    = 12,
  parameter int PAYLOAD_BITS = 160,
  parameter int TIMEOUT_CLKS = 10_000_000
) (
  input logic                 clk,
  input logic                 reset,
  scan_cmd_assembler_if.slave bus
);

  localparam int CMD_BYTES  = cmd_bytes(ADDR_BITS, PAYLOAD_BITS);
  localparam int FRAME_BITS = ADDR_BITS + PAYLOAD_BITS;
  localparam int CW         = $clog2(CMD_BYTES);
  localparam int IW         = $clog2(TIMEOUT_CLKS);

  localparam logic [CW-1:0] LAST_BYTE = CW'(CMD_BYTES - 1);
  localparam logic [IW-1:0] IDLE_MAX  = IW'(TIMEOUT_CLKS - 1);

  asc_state_e            state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [IW-1:0]         idle_q, idle_d;
  logic [FRAME_BITS-1:0] frame_q, frame_d;
  logic                  rdy_q, rdy_d;
  logic                  cv_q, cv_d;
  logic                  rv_q, rv_d;
  logic [7:0]            rsp_q, rsp_d;
  logic                  take;

  assign take = bus.data_valid && rdy_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_COLLECT;
      cnt_q   <= '0;
      idle_q  <= '0;
      frame_q <= '0;
      rdy_q   <= 1'b0;
      cv_q    <= 1'b0;
      rv_q    <= 1'b0;
      rsp_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idle_q  <= idle_d;
      frame_q <= frame_d;
      rdy_q   <= rdy_d;
      cv_q    <= cv_d;
      rv_q    <= rv_d;
      rsp_q   <= rsp_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idle_d  = idle_q;
    frame_d = frame_q;
    rsp_d   = rsp_q;
    unique case (state_q)
      ST_COLLECT: begin
        if (take) begin
          // Pad bits of the last byte have no storage.
          for (int b = 0; b < FRAME_BITS; b++) begin
            if ((b >> 3) == int'(cnt_q)) begin
              frame_d[b] = bus.data_in[b[2:0]];
            end
          end
          idle_d = '0;
          if (cnt_q == LAST_BYTE) begin
            state_d = ST_ISSUE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else if (cnt_q != '0) begin
          if (idle_q == IDLE_MAX) begin
            state_d = ST_RESP;
            cnt_d   = '0;
            idle_d  = '0;
            rsp_d   = ASC_NAK;
          end else begin
            idle_d = idle_q + 1'b1;
          end
        end
      end
      ST_ISSUE: begin
        if (cv_q && bus.cmd_ready) begin
          state_d = ST_RESP;
          rsp_d   = ASC_ACK;
        end
      end
      ST_RESP: begin
        if (rv_q && bus.response_ready) begin
          state_d = ST_COLLECT;
        end
      end
      default: state_d = ST_COLLECT;
    endcase
    // Handshake flags track the next state so they stay registered.
    rdy_d = (state_d == ST_COLLECT);
    cv_d  = (state_d == ST_ISSUE);
    rv_d  = (state_d == ST_RESP);
  end

  assign bus.data_ready     = rdy_q;
  assign bus.cmd_valid      = cv_q;
  assign bus.cmd_addr       = frame_q[ADDR_BITS-1:0];
  assign bus.cmd_payload    = frame_q[FRAME_BITS-1:ADDR_BITS];
  assign bus.response_valid = rv_q;
  assign bus.response_data  = rsp_q;
  assign bus.busy = (state_q != ST_COLLECT) || (cnt_q != '0);

endmodule

// File: tb/tb_scan_cmd_assembler.sv
// Directed bench for scan_cmd_assembler (TIMEOUT_CLKS=100).
// Drives and samples on the falling clock edge.
module tb_scan_cmd_assembler;

  localparam int AB = 12;
  localparam int PB = 160;
  localparam int NB = 22;

  logic clk = 1'b0;
  logic rst_n = 1'b1;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  logic [7:0]      fb [NB];
  logic [NB*8-1:0] fr;
  logic [AB-1:0]   hold_a;
  logic [PB-1:0]   hold_p;
  logic [PB-1:0]   ones_p;
  int              cyc;

  always #5 clk = ~clk;

  scan_cmd_assembler_if #(.ADDR_BITS(AB), .PAYLOAD_BITS(PB)) bus ();

  scan_cmd_assembler #(
    .ADDR_BITS(AB),
    .PAYLOAD_BITS(PB),
    .TIMEOUT_CLKS(100)
  ) dut (
    .clk(clk),
    .reset(rst_n),
    .bus(bus.slave)
  );

  task automatic chk(
    input string        tag,
    input logic [191:0] obs,
    input logic [191:0] exp
  );
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    bus.data_valid = 1'b1;
    bus.data_in    = b;
    while (bus.data_ready !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("byte_accept_wait", 192'(n < 1000), 192'(1));
    @(negedge clk);
    bus.data_valid = 1'b0;
  endtask

  task automatic send_frame();
    for (int k = 0; k < NB; k++) send_byte(fb[k]);
  endtask

  task automatic model();
    for (int k = 0; k < NB; k++) fr[k*8 +: 8] = fb[k];
  endtask

  task automatic fill(input logic [7:0] v);
    for (int k = 0; k < NB; k++) fb[k] = v;
  endtask

  task automatic check_reset_outs(input string tag);
    chk({tag, "_data_ready"}, 192'(bus.data_ready), 192'(0));
    chk({tag, "_cmd_valid"}, 192'(bus.cmd_valid), 192'(0));
    chk({tag, "_resp_valid"}, 192'(bus.response_valid), 192'(0));
    chk({tag, "_busy"}, 192'(bus.busy), 192'(0));
    chk({tag, "_addr"}, 192'(bus.cmd_addr), 192'(0));
    chk({tag, "_payload"}, 192'(bus.cmd_payload), 192'(0));
    chk({tag, "_resp_data"}, 192'(bus.response_data), 192'(0));
  endtask

  // Sinks ready: one cycle of cmd_valid, one of response_valid.
  task automatic check_fast_cmd(
    input string         tag,
    input logic [AB-1:0] ea,
    input logic [PB-1:0] ep
  );
    chk({tag, "_cmd_valid"}, 192'(bus.cmd_valid), 192'(1));
    chk({tag, "_addr"}, 192'(bus.cmd_addr), 192'(ea));
    chk({tag, "_payload"}, 192'(bus.cmd_payload), 192'(ep));
    chk({tag, "_ready_low"}, 192'(bus.data_ready), 192'(0));
    chk({tag, "_busy"}, 192'(bus.busy), 192'(1));
    @(negedge clk);
    chk({tag, "_cmd_drop"}, 192'(bus.cmd_valid), 192'(0));
    chk({tag, "_resp_valid"}, 192'(bus.response_valid), 192'(1));
    chk({tag, "_ack"}, 192'(bus.response_data), 192'(8'h06));
    @(negedge clk);
    chk({tag, "_resp_drop"}, 192'(bus.response_valid), 192'(0));
    chk({tag, "_ready_back"}, 192'(bus.data_ready), 192'(1));
    chk({tag, "_idle"}, 192'(bus.busy), 192'(0));
  endtask

  initial begin
    bus.data_valid     = 1'b0;
    bus.data_in        = 8'h00;
    bus.cmd_ready      = 1'b0;
    bus.response_ready = 1'b0;
    ones_p             = '1;

    #2 rst_n = 1'b0;
    #1 check_reset_outs("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("ready_before_edge", 192'(bus.data_ready), 192'(0));
    @(negedge clk);
    chk("ready_after_edge", 192'(bus.data_ready), 192'(1));

    // Frame 1: 0x34 0x12 then zeros.
    bus.cmd_ready      = 1'b1;
    bus.response_ready = 1'b1;
    fill(8'h00);
    fb[0] = 8'h34;
    fb[1] = 8'h12;
    send_frame();
    check_fast_cmd("f1", 12'h234, 160'h1);

    // Frame 2: all ones, pad nibble must not appear.
    fill(8'hFF);
    send_frame();
    check_fast_cmd("f2", 12'hFFF, ones_p);

    // Frame 3: cmd_ready low 50 cycles while an extra byte waits.
    bus.cmd_ready = 1'b0;
    for (int k = 0; k < NB; k++) fb[k] = 8'(k + 1);
    model();
    send_frame();
    chk("f3_addr", 192'(bus.cmd_addr), 192'(12'h201));
    chk("f3_payload", 192'(bus.cmd_payload), 192'(fr[AB+PB-1:AB]));
    hold_a = bus.cmd_addr;
    hold_p = bus.cmd_payload;
    bus.data_valid = 1'b1;
    bus.data_in    = 8'hAA;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      chk("f3_hold_valid", 192'(bus.cmd_valid), 192'(1));
      chk("f3_hold_addr", 192'(bus.cmd_addr), 192'(hold_a));
      chk("f3_hold_payload", 192'(bus.cmd_payload), 192'(hold_p));
      chk("f3_hold_stall", 192'(bus.data_ready), 192'(0));
    end
    bus.cmd_ready = 1'b1;
    @(negedge clk);
    chk("f3_cmd_drop", 192'(bus.cmd_valid), 192'(0));
    chk("f3_resp", 192'(bus.response_valid), 192'(1));
    chk("f3_ack", 192'(bus.response_data), 192'(8'h06));
    chk("f3_still_stall", 192'(bus.data_ready), 192'(0));
    @(negedge clk);
    chk("f3_ready_back", 192'(bus.data_ready), 192'(1));

    // Frame 4: stalled 0xAA leads, rest zero.
    fill(8'h00);
    fb[0] = 8'hAA;
    send_frame();
    check_fast_cmd("f4", 12'h0AA, 160'h0);

    // Frame 5: response_ready low 20 cycles.
    bus.response_ready = 1'b0;
    fill(8'h5A);
    model();
    send_frame();
    chk("f5_addr", 192'(bus.cmd_addr), 192'(12'hA5A));
    chk("f5_payload", 192'(bus.cmd_payload), 192'(fr[AB+PB-1:AB]));
    bus.data_valid = 1'b1;
    bus.data_in    = 8'h11;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("f5_resp_hold", 192'(bus.response_valid), 192'(1));
      chk("f5_resp_data", 192'(bus.response_data), 192'(8'h06));
      chk("f5_stall", 192'(bus.data_ready), 192'(0));
    end
    bus.data_valid     = 1'b0;
    bus.response_ready = 1'b1;
    @(negedge clk);
    chk("f5_resp_drop", 192'(bus.response_valid), 192'(0));
    chk("f5_ready_back", 192'(bus.data_ready), 192'(1));

    // Timeout: 5 bytes then idle; NAK 100 cycles after last byte.
    bus.response_ready = 1'b0;
    for (int k = 0; k < 5; k++) send_byte(8'h77);
    chk("to_busy", 192'(bus.busy), 192'(1));
    cyc = 0;
    while (bus.response_valid !== 1'b1 && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    chk("to_latency", 192'(cyc), 192'(100));
    chk("to_nak", 192'(bus.response_data), 192'(8'h15));
    chk("to_no_cmd", 192'(bus.cmd_valid), 192'(0));
    bus.response_ready = 1'b1;
    @(negedge clk);
    chk("to_ready_back", 192'(bus.data_ready), 192'(1));
    chk("to_idle", 192'(bus.busy), 192'(0));

    fill(8'h00);
    fb[0] = 8'h78;
    fb[1] = 8'h56;
    fb[2] = 8'h34;
    send_frame();
    check_fast_cmd("to_next", 12'h678, 160'h345);

    // Reset after byte 10 of a frame.
    fill(8'h9C);
    for (int k = 0; k < 10; k++) send_byte(fb[k]);
    chk("rst_partial_addr", 192'(bus.cmd_addr), 192'(12'hC9C));
    rst_n = 1'b0;
    #1 check_reset_outs("rst_mid");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rst_no_resp", 192'(bus.response_valid), 192'(0));
    end
    for (int k = 0; k < NB; k++) fb[k] = 8'(8'hC0 + k);
    model();
    send_frame();
    check_fast_cmd("rst_next", 12'h1C0, fr[AB+PB-1:AB]);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/scan_cmd_assembler.md
# scan_cmd_assembler

Byte-to-command framing stage at the front of the scan-chain subsystem. Consumes the 8-bit valid/ready byte stream that the UART protocol handler routes to the ASC path. Collects one fixed-length frame, presents it as a parallel address+payload command to the scan-chain shifter, and returns a one-byte status on the response stream. An inter-byte timeout discards partial frames so a dropped UART byte cannot desynchronise the host.

## Interface
- ADDR_BITS, 12, scan address width
- PAYLOAD_BITS, 160, scan payload width
- CMD_BYTES, ceil((ADDR_BITS+PAYLOAD_BITS)/8) = 22, frame length in bytes (derived, not overridden)
- TIMEOUT_CLKS, 10_000_000, idle cycles after a partial frame before discard (100 ms at 100 MHz)

- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- data_valid  in  1  byte available from UART handler
- data_ready  out  1  assembler accepts byte
- data_in  in  8  byte from UART handler
- cmd_valid  out  1  assembled command available
- cmd_ready  in  1  shifter accepts command
- cmd_addr  out  ADDR_BITS  frame bits [ADDR_BITS-1:0]
- cmd_payload  out  PAYLOAD_BITS  frame bits [ADDR_BITS+PAYLOAD_BITS-1:ADDR_BITS]
- response_valid  out  1  status byte available
- response_ready  in  1  UART handler accepts status
- response_data  out  8  status byte
- busy  out  1  high in any state other than COLLECT with byte count 0

## Operation
- Frame: CMD_BYTES bytes, little-endian; byte k fills frame bits [8k+7:8k]. Pad bits above ADDR_BITS+PAYLOAD_BITS (4 bits at defaults) are ignored, not checked.
- States: COLLECT, ISSUE, RESP.
- COLLECT: data_ready=1. Each data_valid&&data_ready edge stores the byte and increments byte_cnt. On the edge that accepts byte CMD_BYTES-1, go to ISSUE with byte_cnt=0.
- ISSUE: cmd_valid=1; cmd_addr and cmd_payload are stable until cmd_valid&&cmd_ready. On that edge, go to RESP with response_data=8'h06 (ACK).
- RESP: response_valid=1, response_data stable until response_valid&&response_ready. On that edge, return to COLLECT.
- Timeout: in COLLECT with byte_cnt>0, an idle counter clears on every accepted byte and otherwise increments. When it reaches TIMEOUT_CLKS-1: discard the partial frame, set byte_cnt=0, go to RESP with response_data=8'h15 (NAK). A byte accepted on the same edge wins; no timeout occurs on that edge.
- byte_cnt width is clog2(CMD_BYTES); the idle counter width is clog2(TIMEOUT_CLKS). Neither counter wraps; both are cleared explicitly.
- Bytes offered outside COLLECT stall (data_ready=0). They are never dropped.

## Timing
- data_ready, cmd_valid and response_valid are registered outputs, with no combinational path from inputs.
- Last byte accepted at edge N: data_ready=0 and cmd_valid=1 from edge N.
- cmd handshake at edge M: cmd_valid=0 and response_valid=1 from edge M.
- Response handshake at edge P: data_ready=1 from edge P.
- Minimum frame-to-frame turnaround with ready sinks: CMD_BYTES+2 cycles.
- Reset asserted (reset=0, asynchronous): state=COLLECT, byte_cnt=0, idle counter=0, and all outputs 0, including data_ready, cmd_addr, cmd_payload, response_data and busy.
- First rising edge after reset deassertion: data_ready goes to 1.
- Reset mid-frame or mid-handshake discards everything; no response is emitted.

## Structure
- Shared package scumv_asc_pkg holds:
  - ASC_ACK=8'h06 and ASC_NAK=8'h15;
  - the state enum;
  - a cmd_bytes(addr_bits, payload_bits) function, also used by the scan shifter.
- Single module; no sub-module. Timeout counter and frame register are inline.

## Test plan
- 22 bytes, b0=0x34, b1=0x12, rest 0x00, sinks always ready -> cmd_addr=0x234, cmd_payload=1; cmd_valid exactly 1 cycle; response 0x06.
- 22 bytes of 0xFF -> cmd_addr=0xFFF, cmd_payload all ones; pad bits do not leak into either output.
- cmd_ready held low 50 cycles after the frame -> cmd_valid and data stable for 50 cycles; data_ready=0 throughout; extra bytes stall, then form the next frame correctly.
- TIMEOUT_CLKS=100; send 5 bytes, then idle -> response 0x15 exactly 100 cycles after the last byte; a following full frame decodes correctly.
- response_ready low 20 cycles -> response_valid and response_data held; data_ready stays 0 until the response handshake.
- Reset pulsed after byte 10 -> all outputs 0 during reset; no response; the next 22 bytes form a correct frame.
